// File: rtl/data_mem_param.sv
// MEM-stage data memory: byte-addressed little-endian words,
// registered loads, misalign strobe and post-reset clear.
module data_mem_param #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           Write_data,
  output logic [31:0]           Read_data,
  output logic                  Read_valid,
  output logic                  Misaligned,
  output logic                  Ready
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]   cnt;
  logic [3:0][7:0] mem [DEPTH];

  logic [IW-1:0]   idx;
  logic [1:0]      lane;
  logic            aligned;
  logic            req;
  logic            rej;
  logic            do_store;
  logic            do_load;
  logic            last;
  logic [3:0]      be;
  logic [3:0][7:0] wd;
  logic [3:0][7:0] rword;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [31:0]     ext;

  assign idx  = Address[ADDR_WIDTH-1:2];
  assign lane = Address[1:0];
  assign last = (cnt == IW'(DEPTH - 1));

  // Alignment rule per access size; size 11 is never legal
  always_comb begin
    aligned = 1'b0;
    unique case (Size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~Address[0];
      2'b10:   aligned = (Address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // A store wins over a simultaneous load; reset blocks every request
  assign req      = Ready & ~reset & (MemWrite | MemRead);
  assign rej      = req & ~aligned;
  assign do_store = req & aligned & MemWrite;
  assign do_load  = req & aligned & MemRead & ~MemWrite;

  // Lane enables and replicated store data
  always_comb begin
    be = 4'b0000;
    wd = Write_data;
    unique case (Size)
      2'b00: begin
        be[lane] = 1'b1;
        wd       = {4{Write_data[7:0]}};
      end
      2'b01: begin
        be = Address[1] ? 4'b1100 : 4'b0011;
        wd = {2{Write_data[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!do_store) be = 4'b0000;
  end

  // Select and extend the loaded byte/half
  always_comb begin
    rword = mem[idx];
    bsel  = rword[lane];
    hsel  = Address[1] ? {rword[3], rword[2]}
                       : {rword[1], rword[0]};
    ext   = rword;
    unique case (Size)
      2'b00:   ext = {{24{bsel[7] & ~Unsigned}}, bsel};
      2'b01:   ext = {{16{hsel[15] & ~Unsigned}}, hsel};
      default: ext = rword;
    endcase
  end

  // Next-state: sweep the array once, then serve requests
  always_comb begin
    state_next = state;
    unique case (state)
      CLEAR:   if (last) state_next = IDLE;
      IDLE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    else       state <= state_next;
  end

  // Storage: clear sweep or byte-enabled store
  always_ff @(posedge clk) begin
    if (state == CLEAR && !reset) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wd[i];
      end
    end
  end

  // Output strobes, load data, ready flag and clear counter
  always_ff @(posedge clk) begin
    if (reset) begin
      Read_data  <= '0;
      Read_valid <= 1'b0;
      Misaligned <= 1'b0;
      Ready      <= 1'b0;
      cnt        <= '0;
    end else begin
      Read_valid <= do_load;
      Misaligned <= rej;
      Ready      <= (state_next == IDLE);
      if (do_load) Read_data <= ext;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: doc/data_mem_param.md
Name: data_mem_param

Overview:
- Parametrised, clocked successor to the single-cycle data memory in the MIPS datapath; sits in the MEM stage between the ALU address output and the write-back mux.
- Byte-addressed, little-endian word storage.
- Supports byte/half/word loads and stores (lb/lbu/lh/lhu/lw, sb/sh/sw), with sign or zero extension on loads.
- Registered read with a valid strobe, misaligned-access detection, and a post-reset clear sequencer that zeroes the array before accepting requests.

Parameters:
- ADDR_WIDTH, 10, byte-address width. Word count DEPTH = 2**(ADDR_WIDTH-2). Legal range 3..16.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear and become ready immediately.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- MemWrite  in  1  store request
- MemRead  in  1  load request
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend (ignored for word and for stores)
- Address  in  ADDR_WIDTH  byte address
- Write_data  in  32  store data; byte/half taken from the low bits
- Read_data  out  32  extended load result, registered
- Read_valid  out  1  one-cycle strobe: Read_data updated this cycle
- Misaligned  out  1  one-cycle strobe: previous request rejected
- Ready  out  1  1 = requests accepted this cycle

Behaviour:
- Reset (rising edge with reset=1):
  - Read_data=0, Read_valid=0, Misaligned=0, Ready=0, clear counter=0.
  - Next state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - Reset asserted in any state, including mid-CLEAR, restarts this sequence; the counter returns to 0.
- CLEAR:
  - Each cycle writes 0 to word[cnt] and increments cnt.
  - After writing word DEPTH-1, moves to IDLE. Ready=1 from the following cycle.
  - First Ready=1 is exactly DEPTH cycles after the first cycle with reset=0.
  - All requests are ignored: no array write, no strobes.
- IDLE, Ready=1: a request is sampled at the rising edge.
- Alignment (checked at request):
  - Size=00 is always aligned.
  - Size=01 requires Address[0]=0.
  - Size=10 requires Address[1:0]=00.
  - Size=11 is always rejected.
- Rejected request: no array update, Read_valid=0, Misaligned=1 for exactly the next cycle.
- Store (MemWrite=1, aligned), written at the same edge:
  - Byte: lane Address[1:0] <= Write_data[7:0].
  - Half: lanes {Address[1],1},{Address[1],0} <= Write_data[15:0].
  - Word: all four lanes.
  - Other lanes are unchanged. Word index is Address[ADDR_WIDTH-1:2].
- Load (MemRead=1, MemWrite=0, aligned):
  - Read_data and Read_valid=1 are presented in the cycle after the request (1-cycle latency).
  - The selected byte/half is extended per Unsigned.
- MemWrite=1 and MemRead=1 together: the store is performed and the read is dropped (Read_valid=0). Misaligned is evaluated on the store.
- Load in the cycle immediately after a store to the same word returns the new data; no stale read.
- Read_data holds its last value whenever Read_valid=0. Read_valid and Misaligned are never both 1.
- Back-to-back loads give one Read_valid per cycle (full throughput).
- Address wraps naturally within ADDR_WIDTH; no out-of-range condition exists.

Test Plan:
1. Reset 1 cycle, ADDR_WIDTH=10 -> Ready rises exactly 256 cycles later. Load issued while Ready=0 -> no Read_valid. lw at 0x3FC after Ready -> 0x00000000.
2. sw 32 @0x014, sw 104 @0x03C, then lw 0x014, lw 0x03C back-to-back -> Read_valid on two consecutive cycles, Read_data 32 then 104.
3. sw 0x80FF7F01 @0x040, then loads:
   - lb 0x040 -> 0x00000001
   - lb 0x043 -> 0xFFFFFF80
   - lbu 0x043 -> 0x00000080
   - lh 0x042 -> 0xFFFF80FF
   - lhu 0x040 -> 0x00007F01
4. sb 0xAA @0x041 on that word, then lw 0x040 -> 0x80FFAA01. Then sh 0x1234 @0x042, lw 0x040 -> 0x1234AA01.
5. Misaligned requests, each -> Misaligned=1 for one cycle, Read_valid=0, array unchanged:
   - sw @0x042 (lw 0x040 still 0x1234AA01)
   - lh @0x041
   - Size=11 @0x000
6. Simultaneous events:
   - MemWrite=MemRead=1 sw 7 @0x080 -> no Read_valid; next lw 0x080 -> 7.
   - Reset asserted at clear count 100 -> Ready stays 0 and a full 256-cycle clear restarts; a previously stored value reads back 0.
